// File: rtl/sram_bus_ctrl_if.sv
// AVR-side handshake and SRAM address/strobe signals for sram_bus_ctrl.
// The two bidirectional data buses are kept as plain inout ports on the
// controller so that tristate resolution stays at module boundaries.
interface sram_bus_ctrl_if #(
  parameter int AWIDTH = 16
);
  logic              avr_req;
  logic              avr_rw;
  logic [AWIDTH-1:0] avr_addr;
  logic              avr_oe;
  logic              avr_ack;
  logic              busy;
  logic [AWIDTH-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  // Controller side: takes AVR requests, drives the SRAM strobes
  modport slave (
    input  avr_req, avr_rw, avr_addr, avr_oe,
    output avr_ack, busy, sram_addr, sram_ce_n, sram_oe_n, sram_we_n
  );

  // Environment side: issues requests, observes strobes and acknowledge
  modport master (
    output avr_req, avr_rw, avr_addr, avr_oe,
    input  avr_ack, busy, sram_addr, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// SRAM access sequencer between the AVR data/address bus and an external
// asynchronous SRAM. Each accepted request runs a full cycle: optional bus
// turnaround, address setup, WAIT_STATES+1 access cycles, data hold, and a
// single-cycle acknowledge. Every strobe and status output is a register
// loaded from the next-state value, so nothing visible off-chip glitches.
module sram_bus_ctrl #(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_bus_ctrl_if.slave   bus,
  inout  wire [DWIDTH-1:0] avr_data,
  inout  wire [DWIDTH-1:0] sram_data
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] WS_INIT = CW'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, TURN, SETUP, ACCESS, HOLD} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              last_rw_q, last_rw_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wr_data_q, wr_data_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              drv_q, drv_d;
  logic              accept;

  // State and all output/data registers; reset also aborts a cycle in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b1;
      last_rw_q  <= 1'b1;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      drv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      last_rw_q  <= last_rw_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      drv_q      <= drv_d;
    end
  end

  // Next-state logic; the wait-state counter is loaded on leaving SETUP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:   if (bus.avr_req) state_d = (bus.avr_rw != last_rw_q) ? TURN : SETUP;
      TURN:   state_d = SETUP;
      SETUP:  begin
        state_d = ACCESS;
        cnt_d   = WS_INIT;
      end
      ACCESS: if (cnt_q == '0) state_d = HOLD;
              else cnt_d = cnt_q - 1'b1;
      HOLD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, read-data latch and direction history
  always_comb begin
    accept     = (state_q == IDLE) && bus.avr_req;
    rw_d       = accept ? bus.avr_rw : rw_q;
    addr_d     = accept ? bus.avr_addr : addr_q;
    wr_data_d  = (accept && !bus.avr_rw) ? avr_data : wr_data_q;
    rd_valid_d = accept ? 1'b0 : rd_valid_q;
    rd_data_d  = rd_data_q;
    last_rw_d  = (state_q == HOLD) ? rw_q : last_rw_q;
    if (state_q == ACCESS && cnt_q == '0 && rw_q) begin
      rd_data_d  = sram_data;
      rd_valid_d = 1'b1;
    end
  end

  // Registered outputs derived from the state being entered next
  always_comb begin
    ce_n_d = !(state_d inside {SETUP, ACCESS, HOLD});
    oe_n_d = !(state_d == ACCESS && rw_d);
    we_n_d = !(state_d == ACCESS && !rw_d);
    ack_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);
    drv_d  = !rw_d && (state_d inside {SETUP, ACCESS, HOLD});
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_ce_n = ce_n_q;
  assign bus.sram_oe_n = oe_n_q;
  assign bus.sram_we_n = we_n_q;
  assign bus.avr_ack   = ack_q;
  assign bus.busy      = busy_q;

  assign sram_data = drv_q ? wr_data_q : 'z;
  assign avr_data  = (bus.avr_oe && rd_valid_q) ? rd_data_q : 'z;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Testbench for sram_bus_ctrl: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance, each with its own SRAM memory model. Undriven data buses are
// pulled up, so a released bus reads all ones.
module tb_sram_bus_ctrl;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_bus_ctrl_if #(.AWIDTH(16)) bus0 ();
  sram_bus_ctrl_if #(.AWIDTH(16)) bus1 ();

  wire [7:0] avrData0, sramData0, avrData1, sramData1;
  pullup pu0 (avrData0);
  pullup pu1 (sramData0);
  pullup pu2 (avrData1);
  pullup pu3 (sramData1);

  logic       avrDrv0 = 1'b0, avrDrv1 = 1'b0;
  logic [7:0] avrOut0 = '0, avrOut1 = '0;
  assign avrData0 = avrDrv0 ? avrOut0 : 'z;
  assign avrData1 = avrDrv1 ? avrOut1 : 'z;

  sram_bus_ctrl #(.DWIDTH(8), .AWIDTH(16), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .avr_data(avrData0), .sram_data(sramData0));
  sram_bus_ctrl #(.DWIDTH(8), .AWIDTH(16), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .avr_data(avrData1), .sram_data(sramData1));

  // SRAM models: asynchronous read while selected and output-enabled
  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];
  logic        pokeEn0 = 1'b0, pokeEn1 = 1'b0;
  logic [15:0] pokeAddr0 = '0, pokeAddr1 = '0;
  logic [7:0]  pokeVal0 = '0, pokeVal1 = '0;

  assign sramData0 = (!bus0.sram_ce_n && !bus0.sram_oe_n && bus0.sram_we_n) ? mem0[bus0.sram_addr] : 'z;
  assign sramData1 = (!bus1.sram_ce_n && !bus1.sram_oe_n && bus1.sram_we_n) ? mem1[bus1.sram_addr] : 'z;

  always @(posedge clk) begin
    if (!bus0.sram_ce_n && !bus0.sram_we_n) mem0[bus0.sram_addr] <= sramData0;
    if (pokeEn0) mem0[pokeAddr0] <= pokeVal0;
    if (!bus1.sram_ce_n && !bus1.sram_we_n) mem1[bus1.sram_addr] <= sramData1;
    if (pokeEn1) mem1[pokeAddr1] <= pokeVal1;
  end

  int checks = 0;
  int failures = 0;

  // Reference model state: direction of the last completed cycle per instance
  bit lastRw0 = 1'b1, lastRw1 = 1'b1;

  // Observations of the most recent transaction
  int         ceLowN, oeLowN, weLowN, ackN, ackIdx, ceFirst, zBadN, sramMatchN;
  logic [15:0] addrAtSetup;
  logic       obsCe [0:31];
  logic       obsWe [0:31];
  logic       obsBusy [0:31];
  logic [7:0] obsSd [0:31];
  logic [7:0] obsAvr [0:31];

  function automatic int expLatency(input bit rw, input bit lastRw, input int ws);
    return ws + 3 + ((rw != lastRw) ? 1 : 0);
  endfunction

  task automatic setReq(input bit sel, input logic req, input logic rw, input logic [15:0] addr);
    if (sel) begin bus1.avr_req = req; bus1.avr_rw = rw; bus1.avr_addr = addr; end
    else     begin bus0.avr_req = req; bus0.avr_rw = rw; bus0.avr_addr = addr; end
  endtask

  task automatic setAvr(input bit sel, input logic drv, input logic [7:0] val);
    if (sel) begin avrDrv1 = drv; avrOut1 = val; end
    else     begin avrDrv0 = drv; avrOut0 = val; end
  endtask

  task automatic setOe(input bit sel, input logic oe);
    if (sel) bus1.avr_oe = oe;
    else     bus0.avr_oe = oe;
  endtask

  task automatic poke(input bit sel, input logic [15:0] addr, input logic [7:0] val);
    @(negedge clk);
    if (sel) begin pokeEn1 = 1'b1; pokeAddr1 = addr; pokeVal1 = val; end
    else     begin pokeEn0 = 1'b1; pokeAddr0 = addr; pokeVal0 = val; end
    @(negedge clk);
    pokeEn0 = 1'b0;
    pokeEn1 = 1'b0;
  endtask

  // Issues one request and records n samples, one per cycle after the accepting edge
  task automatic runTxn(input bit sel, input bit rw, input logic [15:0] addr, input logic [7:0] data,
                        input bit holdReq, input bit scramble, input int resetAt, input int n);
    logic ce, oe, we, ack, busy;
    logic [7:0] sd, ad;
    logic [15:0] sa;
    ceLowN = 0; oeLowN = 0; weLowN = 0; ackN = 0; ackIdx = 0; ceFirst = 0;
    zBadN = 0; sramMatchN = 0; addrAtSetup = '0;
    @(negedge clk);
    setReq(sel, 1'b1, rw, addr);
    setAvr(sel, !rw, data);
    @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ce   = sel ? bus1.sram_ce_n : bus0.sram_ce_n;
      oe   = sel ? bus1.sram_oe_n : bus0.sram_oe_n;
      we   = sel ? bus1.sram_we_n : bus0.sram_we_n;
      ack  = sel ? bus1.avr_ack   : bus0.avr_ack;
      busy = sel ? bus1.busy      : bus0.busy;
      sd   = sel ? sramData1      : sramData0;
      ad   = sel ? avrData1       : avrData0;
      sa   = sel ? bus1.sram_addr : bus0.sram_addr;
      obsCe[i] = ce; obsWe[i] = we; obsBusy[i] = busy; obsSd[i] = sd; obsAvr[i] = ad;
      if (!ce) begin
        ceLowN++;
        if (ceFirst == 0) begin ceFirst = i; addrAtSetup = sa; end
        if (!rw && sd === data) sramMatchN++;
      end
      if (!oe) oeLowN++;
      if (!we) weLowN++;
      if (ack) begin ackN++; if (ackIdx == 0) ackIdx = i; end
      if (!(!rw && !ce) && oe && sd !== 8'hFF) zBadN++;
      if (i == 1) begin
        if (!holdReq) setReq(sel, 1'b0, rw, addr);
        if (!holdReq) setAvr(sel, 1'b0, 8'h00);
        if (scramble) begin
          setReq(sel, holdReq, ~rw, ~addr);
          setAvr(sel, 1'b1, ~data);
        end
      end
      if (resetAt != 0 && i == resetAt) rst_n = 1'b0;
      if (resetAt != 0 && i == resetAt + 1) rst_n = 1'b1;
    end
    setReq(sel, 1'b0, rw, addr);
    setAvr(sel, 1'b0, 8'h00);
  endtask

  task automatic waitIdle(input bit sel);
    int k;
    k = 0;
    while ((sel ? bus1.busy : bus0.busy) && k < 40) begin @(negedge clk); k++; end
    checks++; if ((sel ? bus1.busy : bus0.busy) !== 1'b0) begin failures++; $display("[TB] FAIL idle_timeout: busy=1 after %0d cycles, required 0", k); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    setOe(0, 1'b1);
    #1;
    checks++; if (bus0.sram_ce_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_ce_n: got %b, required 1", bus0.sram_ce_n); end
    checks++; if (bus0.sram_oe_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_oe_n: got %b, required 1", bus0.sram_oe_n); end
    checks++; if (bus0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_we_n: got %b, required 1", bus0.sram_we_n); end
    checks++; if (bus0.avr_ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack: got %b, required 0", bus0.avr_ack); end
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b, required 0", bus0.busy); end
    checks++; if (bus0.sram_addr !== 16'h0000) begin failures++; $display("[TB] FAIL rst_addr: got %h, required 0000", bus0.sram_addr); end
    checks++; if (sramData0 !== 8'hFF) begin failures++; $display("[TB] FAIL rst_sram_z: got %h, required released (ff)", sramData0); end
    checks++; if (avrData0 !== 8'hFF) begin failures++; $display("[TB] FAIL rst_avr_z: got %h, required released (ff)", avrData0); end
    checks++; if (bus1.busy !== 1'b0 || bus1.sram_ce_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_inst1: busy=%b ce_n=%b, required 0/1", bus1.busy, bus1.sram_ce_n); end
    setOe(0, 1'b0);
    rst_n = 1'b1;
    lastRw0 = 1'b1;
    lastRw1 = 1'b1;
  endtask

  task automatic test_write();
    int l;
    l = expLatency(1'b0, lastRw0, WS0);
    runTxn(0, 1'b0, 16'h1234, 8'hA5, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ceFirst !== 2) begin failures++; $display("[TB] FAIL wr_turn: first ce_n low at %0d, required 2", ceFirst); end
    checks++; if (weLowN !== WS0 + 1) begin failures++; $display("[TB] FAIL wr_we_len: got %0d, required %0d", weLowN, WS0 + 1); end
    checks++; if (oeLowN !== 0) begin failures++; $display("[TB] FAIL wr_oe_len: got %0d, required 0", oeLowN); end
    checks++; if (sramMatchN !== WS0 + 3) begin failures++; $display("[TB] FAIL wr_data_held: got %0d cycles, required %0d", sramMatchN, WS0 + 3); end
    checks++; if (ackIdx !== l || ackN !== 1) begin failures++; $display("[TB] FAIL wr_ack: at %0d count %0d, required at %0d count 1", ackIdx, ackN, l); end
    checks++; if (addrAtSetup !== 16'h1234) begin failures++; $display("[TB] FAIL wr_addr: got %h, required 1234", addrAtSetup); end
    checks++; if (zBadN !== 0) begin failures++; $display("[TB] FAIL wr_bus_z: %0d driven cycles, required 0", zBadN); end
    checks++; if (obsBusy[l] !== 1'b1 || obsBusy[l + 1] !== 1'b0) begin failures++; $display("[TB] FAIL wr_busy: %b%b, required 10", obsBusy[l], obsBusy[l + 1]); end
    checks++; if (mem0[16'h1234] !== 8'hA5) begin failures++; $display("[TB] FAIL wr_mem: got %h, required a5", mem0[16'h1234]); end
    lastRw0 = 1'b0;
  endtask

  task automatic test_read_after_write();
    int l;
    poke(0, 16'h1234, 8'h5A);
    l = expLatency(1'b1, lastRw0, WS0);
    runTxn(0, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ceFirst !== 2) begin failures++; $display("[TB] FAIL rd_turn: first ce_n low at %0d, required 2", ceFirst); end
    checks++; if (oeLowN !== WS0 + 1 || weLowN !== 0) begin failures++; $display("[TB] FAIL rd_strobes: oe %0d we %0d, required %0d/0", oeLowN, weLowN, WS0 + 1); end
    checks++; if (ackIdx !== l || ackN !== 1) begin failures++; $display("[TB] FAIL rd_ack: at %0d count %0d, required at %0d count 1", ackIdx, ackN, l); end
    checks++; if (zBadN !== 0) begin failures++; $display("[TB] FAIL rd_bus_z: %0d driven cycles, required 0", zBadN); end
    setOe(0, 1'b1);
    #1;
    checks++; if (avrData0 !== 8'h5A) begin failures++; $display("[TB] FAIL rd_avr_data: got %h, required 5a", avrData0); end
    setOe(0, 1'b0);
    #1;
    checks++; if (avrData0 !== 8'hFF) begin failures++; $display("[TB] FAIL rd_avr_z: got %h, required released (ff)", avrData0); end
    lastRw0 = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v1, v2;
    int l;
    v1 = 8'($urandom_range(0, 126));
    v2 = 8'($urandom_range(127, 254));
    poke(0, 16'h0001, v1);
    poke(0, 16'h0002, v2);
    setOe(0, 1'b1);
    l = expLatency(1'b1, lastRw0, WS0);
    runTxn(0, 1'b1, 16'h0001, 8'h00, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ackIdx !== 5 || ceFirst !== 1) begin failures++; $display("[TB] FAIL b2b_first: ack %0d ce %0d, required 5/1", ackIdx, ceFirst); end
    checks++; if (obsAvr[l + 1] !== v1) begin failures++; $display("[TB] FAIL b2b_first_data: got %h, required %h", obsAvr[l + 1], v1); end
    runTxn(0, 1'b1, 16'h0002, 8'h00, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ackIdx !== 5 || ceFirst !== 1) begin failures++; $display("[TB] FAIL b2b_second: ack %0d ce %0d, required 5/1", ackIdx, ceFirst); end
    checks++; if (obsAvr[1] !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_valid_clear: got %h, required released (ff)", obsAvr[1]); end
    checks++; if (obsAvr[l + 1] !== v2) begin failures++; $display("[TB] FAIL b2b_second_data: got %h, required %h", obsAvr[l + 1], v2); end
    setOe(0, 1'b0);
    lastRw0 = 1'b1;
  endtask

  task automatic test_ignored_req();
    logic [15:0] a;
    logic [7:0] d;
    int l;
    a = 16'($urandom);
    d = 8'($urandom_range(0, 254));
    l = expLatency(1'b0, lastRw0, WS0);
    runTxn(0, 1'b0, a, d, 1'b1, 1'b0, 0, l + 2);
    checks++; if (ackN !== 1 || ackIdx !== l) begin failures++; $display("[TB] FAIL hold_ack: count %0d at %0d, required 1 at %0d", ackN, ackIdx, l); end
    checks++; if (obsBusy[l + 1] !== 1'b0 || obsBusy[l + 2] !== 1'b1) begin failures++; $display("[TB] FAIL hold_reaccept: busy %b%b, required 01", obsBusy[l + 1], obsBusy[l + 2]); end
    checks++; if (weLowN !== WS0 + 1) begin failures++; $display("[TB] FAIL hold_we_len: got %0d, required %0d", weLowN, WS0 + 1); end
    waitIdle(0);
    checks++; if (mem0[a] !== d) begin failures++; $display("[TB] FAIL hold_mem: got %h, required %h", mem0[a], d); end
    lastRw0 = 1'b0;
  endtask

  task automatic test_random();
    bit rw, scr, turn;
    logic [15:0] a;
    logic [7:0] d;
    int l;
    for (int t = 0; t < 10; t++) begin
      rw  = 1'($urandom_range(0, 1));
      scr = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      d   = 8'($urandom_range(0, 254));
      if (rw) poke(0, a, d);
      turn = (rw != lastRw0);
      l = expLatency(rw, lastRw0, WS0);
      runTxn(0, rw, a, d, 1'b0, scr, 0, l + 1);
      checks++; if (ackIdx !== l || ackN !== 1) begin failures++; $display("[TB] FAIL rnd%0d_ack: at %0d count %0d, required at %0d count 1", t, ackIdx, ackN, l); end
      checks++; if (ceFirst !== (turn ? 2 : 1)) begin failures++; $display("[TB] FAIL rnd%0d_turn: first ce_n low at %0d, required %0d", t, ceFirst, turn ? 2 : 1); end
      checks++; if (addrAtSetup !== a) begin failures++; $display("[TB] FAIL rnd%0d_addr: got %h, required %h", t, addrAtSetup, a); end
      checks++; if ((rw ? oeLowN : weLowN) !== WS0 + 1 || (rw ? weLowN : oeLowN) !== 0) begin failures++; $display("[TB] FAIL rnd%0d_strobes: oe %0d we %0d, rw %0d", t, oeLowN, weLowN, rw); end
      checks++; if (zBadN !== 0) begin failures++; $display("[TB] FAIL rnd%0d_bus_z: %0d driven cycles, required 0", t, zBadN); end
      if (rw) begin
        setOe(0, 1'b1);
        #1;
        checks++; if (avrData0 !== d) begin failures++; $display("[TB] FAIL rnd%0d_rdata: got %h, required %h", t, avrData0, d); end
        setOe(0, 1'b0);
      end else begin
        checks++; if (mem0[a] !== d) begin failures++; $display("[TB] FAIL rnd%0d_wdata: got %h, required %h", t, mem0[a], d); end
      end
      lastRw0 = rw;
    end
  endtask

  task automatic test_mid_reset();
    int r, l;
    logic [15:0] a;
    logic [7:0] d;
    a = 16'($urandom);
    d = 8'($urandom_range(0, 254));
    r = ((lastRw0 != 1'b0) ? 2 : 1) + 1;
    runTxn(0, 1'b0, a, d, 1'b0, 1'b0, r, r + 8);
    checks++; if (obsWe[r] !== 1'b0) begin failures++; $display("[TB] FAIL mrst_in_access: we_n %b, required 0", obsWe[r]); end
    checks++; if (obsCe[r + 1] !== 1'b1 || obsWe[r + 1] !== 1'b1) begin failures++; $display("[TB] FAIL mrst_strobes: ce_n %b we_n %b, required 1/1", obsCe[r + 1], obsWe[r + 1]); end
    checks++; if (obsSd[r + 1] !== 8'hFF) begin failures++; $display("[TB] FAIL mrst_sram_z: got %h, required released (ff)", obsSd[r + 1]); end
    checks++; if (obsBusy[r + 1] !== 1'b0) begin failures++; $display("[TB] FAIL mrst_busy: got %b, required 0", obsBusy[r + 1]); end
    checks++; if (ackN !== 0) begin failures++; $display("[TB] FAIL mrst_no_ack: got %0d pulses, required 0", ackN); end
    lastRw0 = 1'b1;
    lastRw1 = 1'b1;
    l = expLatency(1'b0, lastRw0, WS0);
    runTxn(0, 1'b0, a, d, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ceFirst !== 2 || ackIdx !== WS0 + 4) begin failures++; $display("[TB] FAIL mrst_next_turn: ce %0d ack %0d, required 2/%0d", ceFirst, ackIdx, WS0 + 4); end
    lastRw0 = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [15:0] a, b;
    logic [7:0] d, e;
    int l;
    a = 16'($urandom);
    b = a ^ 16'h8001;
    d = 8'($urandom_range(0, 254));
    e = 8'($urandom_range(0, 254));
    l = expLatency(1'b0, lastRw1, WS1);
    runTxn(1, 1'b0, a, d, 1'b0, 1'b0, 0, l + 1);
    checks++; if (weLowN !== 1 || ackIdx !== 4) begin failures++; $display("[TB] FAIL zw_write: we %0d ack %0d, required 1/4", weLowN, ackIdx); end
    checks++; if (mem1[a] !== d) begin failures++; $display("[TB] FAIL zw_wmem: got %h, required %h", mem1[a], d); end
    lastRw1 = 1'b0;
    l = expLatency(1'b1, lastRw1, WS1);
    runTxn(1, 1'b1, a, 8'h00, 1'b0, 1'b0, 0, l + 1);
    checks++; if (oeLowN !== 1 || ackIdx !== 4) begin failures++; $display("[TB] FAIL zw_read_turn: oe %0d ack %0d, required 1/4", oeLowN, ackIdx); end
    setOe(1, 1'b1);
    #1;
    checks++; if (avrData1 !== d) begin failures++; $display("[TB] FAIL zw_rdata: got %h, required %h", avrData1, d); end
    setOe(1, 1'b0);
    lastRw1 = 1'b1;
    poke(1, b, e);
    l = expLatency(1'b1, lastRw1, WS1);
    runTxn(1, 1'b1, b, 8'h00, 1'b0, 1'b0, 0, l + 1);
    checks++; if (ackIdx !== 3 || ceFirst !== 1 || oeLowN !== 1) begin failures++; $display("[TB] FAIL zw_read: ack %0d ce %0d oe %0d, required 3/1/1", ackIdx, ceFirst, oeLowN); end
    setOe(1, 1'b1);
    #1;
    checks++; if (avrData1 !== e) begin failures++; $display("[TB] FAIL zw_rdata2: got %h, required %h", avrData1, e); end
    setOe(1, 1'b0);
  endtask

  initial begin
    setReq(0, 1'b0, 1'b1, 16'h0000);
    setReq(1, 1'b0, 1'b1, 16'h0000);
    setOe(0, 1'b0);
    setOe(1, 1'b0);
    test_reset();
    test_write();
    test_read_after_write();
    test_back_to_back();
    test_ignored_req();
    test_random();
    test_mid_reset();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
